// File: rtl/rf_pkg.sv
// Register-file constants shared by the register file, the writeback arbiter and the scoreboard.
package rf_pkg;

    localparam int          REG_AW   = 5;
    localparam int          REG_DW   = 32;
    localparam int          NUM_REGS = 32;
    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [4:0]  REG_SP   = 5'd29;
    localparam logic [31:0] SP_RESET = 32'h7ffffffc;

endpackage

// File: rtl/rr_arb.sv
// Round-robin picker: grants the first requester at or after ptr, searching cyclically over 0..N-1.
module rr_arb #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: requester 0 has priority, the rest share the port round-robin.
// Also keeps the busy scoreboard of registers with outstanding claimed writes.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               claim_valid,
    input  logic [AW-1:0]      claim_addr,
    output logic               rf_wr,
    output logic [AW-1:0]      rf_addr,
    output logic [DW-1:0]      rf_data,
    output logic [2**AW-1:0]   busy
);

    localparam int PW  = $clog2(NREQ);
    localparam int NRR = NREQ - 1;
    localparam int RW  = (NRR > 1) ? $clog2(NRR) : 1;

    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             rf_wr_q, rf_wr_d;
    logic [AW-1:0]    rf_addr_q, rf_addr_d;
    logic [DW-1:0]    rf_data_q, rf_data_d;
    logic [2**AW-1:0] busy_q, busy_d;

    logic [RW-1:0]    rr_base;
    logic [RW-1:0]    rr_idx;
    logic [NRR-1:0]   rr_gnt;
    logic             gnt_any;
    logic [PW-1:0]    gnt_idx;
    logic [AW-1:0]    gnt_addr;
    logic [DW-1:0]    gnt_data;

    // rr_ptr counts in requester numbers (1..NREQ-1); the picker works on 0-based pool indices.
    assign rr_base = RW'(int'(rr_ptr_q) - 1);

    rr_arb #(
        .N  (NRR),
        .IW (RW)
    ) u_rr_arb (
        .req     (req_valid[NREQ-1:1]),
        .ptr     (rr_base),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    always_comb begin
        req_ready = '0;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        if (req_valid[0]) begin
            req_ready[0] = 1'b1;
            gnt_any      = 1'b1;
        end else if (|req_valid[NREQ-1:1]) begin
            req_ready[NREQ-1:1] = rr_gnt;
            gnt_any             = 1'b1;
            gnt_idx             = PW'(int'(rr_idx) + 1);
        end
        gnt_addr = req_addr[int'(gnt_idx)*AW +: AW];
        gnt_data = req_data[int'(gnt_idx)*DW +: DW];
    end

    always_comb begin
        int nxt;
        nxt       = int'(gnt_idx) + 1;
        rr_ptr_d  = rr_ptr_q;
        rf_wr_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (gnt_any) begin
            rf_wr_d   = (gnt_addr != '0);
            rf_addr_d = gnt_addr;
            rf_data_d = gnt_data;
            if (gnt_idx != '0) begin
                rr_ptr_d = (nxt >= NREQ) ? PW'(1) : PW'(nxt);
            end
        end
    end

    // A claim in the same cycle as a write to that register wins: the new claim outlives the old write.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < 2**AW; r++) begin
            if (claim_valid && (int'(claim_addr) == r)) begin
                busy_d[r] = 1'b1;
            end else if (gnt_any && (int'(gnt_addr) == r)) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q  <= PW'(1);
            rf_wr_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rf_wr_q   <= rf_wr_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            busy_q    <= busy_d;
        end
    end

    assign rf_wr   = rf_wr_q;
    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_rf_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               claim_valid;
    logic [AW-1:0]      claim_addr;
    logic               rf_wr;
    logic [AW-1:0]      rf_addr;
    logic [DW-1:0]      rf_data;
    logic [2**AW-1:0]   busy;

    rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .rf_wr       (rf_wr),
        .rf_addr     (rf_addr),
        .rf_data     (rf_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference state
    int               m_ptr = 1;
    bit               m_wr = 1'b0;
    bit [AW-1:0]      m_addr = '0;
    bit [DW-1:0]      m_data = '0;
    bit [2**AW-1:0]   m_busy = '0;
    logic [NREQ-1:0]  last_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Priority to 0, else first valid requester at or after the pointer, cycling through 1..NREQ-1.
    function automatic int model_grant(input bit [NREQ-1:0] v, input int ptr);
        int c;
        if (v[0]) return 0;
        for (int k = 0; k < NREQ - 1; k++) begin
            c = ((ptr - 1 + k) % (NREQ - 1)) + 1;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic apply(input bit rst, input bit [NREQ-1:0] v, input bit [NREQ*AW-1:0] a,
                         input bit [NREQ*DW-1:0] d, input bit cv, input bit [AW-1:0] ca);
        int          g;
        bit [AW-1:0] ga;
        @(negedge clk);
        reset       = ~rst;
        req_valid   = v;
        req_addr    = a;
        req_data    = d;
        claim_valid = cv;
        claim_addr  = ca;
        #1;
        g = model_grant(v, m_ptr);
        last_ready = req_ready;
        chk("ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        @(posedge clk);
        if (rst) begin
            m_wr = 1'b0; m_addr = '0; m_data = '0; m_busy = '0; m_ptr = 1;
        end else begin
            m_wr = 1'b0;
            if (g >= 0) begin
                ga     = a[g*AW +: AW];
                m_wr   = (ga != 0);
                m_addr = ga;
                m_data = d[g*DW +: DW];
                if (g >= 1) m_ptr = (g + 1 >= NREQ) ? 1 : g + 1;
                m_busy[ga] = 1'b0;
            end
            if (cv) m_busy[ca] = 1'b1;
            m_busy[0] = 1'b0;
        end
        #1;
        chk("rf_wr", 64'(rf_wr), 64'(m_wr));
        chk("rf_addr", 64'(rf_addr), 64'(m_addr));
        chk("rf_data", 64'(rf_data), 64'(m_data));
        chk("busy", 64'(busy), 64'(m_busy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, '0, '0, '0, 0, '0);
    endtask

    task automatic do_reset();
        apply(1, '0, '0, '0, 0, '0);
        apply(1, '0, '0, '0, 0, '0);
    endtask

    initial begin
        reset = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        claim_valid = 1'b0; claim_addr = '0;

        // reset then idle
        do_reset();
        idle(1);
        chk("rst_wr", 64'(rf_wr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);

        // single write from requester 1
        apply(0, 3'b010, {5'd3, 5'd8, 5'd1}, {32'h1, 32'hDEADBEEF, 32'h2}, 0, '0);
        chk("single_ready", 64'(last_ready), 64'b010);
        chk("single_wr", 64'(rf_wr), 64'd1);
        chk("single_addr", 64'(rf_addr), 64'd8);
        chk("single_data", 64'(rf_data), 64'hDEADBEEF);

        // priority then round robin from a fresh pointer
        do_reset();
        begin
            bit [NREQ-1:0] exp_seq [8] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010, 3'b100};
            for (int i = 0; i < 8; i++) begin
                apply(0, (i < 4) ? 3'b111 : 3'b110, {5'd12, 5'd11, 5'd10},
                      {32'(i), 32'(i + 100), 32'(i + 200)}, 0, '0);
                chk("rr_seq", 64'(last_ready), 64'(exp_seq[i]));
            end
        end

        // write to register zero is accepted then dropped
        apply(0, 3'b001, {5'd1, 5'd1, 5'd0}, {32'h0, 32'h0, 32'h5}, 0, '0);
        chk("zero_ready", 64'(last_ready), 64'b001);
        chk("zero_wr", 64'(rf_wr), 64'd0);

        // scoreboard set/clear and set-wins collision
        apply(0, '0, '0, '0, 1, 5'd9);
        chk("sb_set", 64'(busy[9]), 64'd1);
        idle(2);
        apply(0, 3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0}, 1, 5'd9);
        chk("sb_setwins", 64'(busy[9]), 64'd1);
        idle(1);
        apply(0, 3'b100, {5'd9, 5'd0, 5'd0}, {32'h77, 32'h0, 32'h0}, 0, '0);
        chk("sb_clear", 64'(busy[9]), 64'd0);

        // reset in the middle of activity
        apply(0, '0, '0, '0, 1, 5'd4);
        apply(0, 3'b100, {5'd20, 5'd0, 5'd0}, {32'h1, 32'h0, 32'h0}, 1, 5'd7);
        apply(1, 3'b010, {5'd0, 5'd15, 5'd0}, {32'h0, 32'hABCD, 32'h0}, 1, 5'd4);
        chk("mid_rst_wr", 64'(rf_wr), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        apply(0, 3'b110, {5'd2, 5'd3, 5'd0}, {32'h22, 32'h33, 32'h0}, 0, '0);
        chk("mid_rst_ptr", 64'(last_ready), 64'b010);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit [NREQ*AW-1:0] a;
            bit [NREQ*DW-1:0] d;
            for (int k = 0; k < NREQ; k++) begin
                a[k*AW +: AW] = AW'($urandom_range(0, 7));
                d[k*DW +: DW] = $urandom;
            end
            apply($urandom_range(0, 49) == 0, NREQ'($urandom) & ($urandom_range(0, 3) == 0 ? 3'b110 : 3'b111),
                  a, d, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (wr/addr3/data3) among NREQ writeback sources: main pipeline, multiply/divide unit, load unit.
- Requester 0 (main pipeline) has absolute priority. Requesters 1..NREQ-1 are served round-robin.
- Keeps a busy scoreboard of registers with outstanding claimed writes, used by issue logic for hazard stalls.
- Sits between the writeback sources and the register file. Its outputs drive the register file write port directly.

Parameters:
- NREQ, 3, number of write requesters (2..8).
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset, sampled on rising clk.
- req_valid  in  NREQ  requester i has a write pending.
- req_addr  in  NREQ*AW  destination register per requester; slice i = [i*AW +: AW].
- req_data  in  NREQ*DW  write data per requester; slice i = [i*DW +: DW].
- req_ready  out  NREQ  grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
- claim_valid  in  1  issue logic reserves claim_addr for a future write.
- claim_addr  in  AW  register being reserved.
- rf_wr  out  1  to register file wr.
- rf_addr  out  AW  to register file addr3.
- rf_data  out  DW  to register file data3.
- busy  out  2**AW  scoreboard; bit r = 1 means register r has an outstanding claimed write.

Behaviour:
- Reset (reset==0 at rising clk) clears rf_wr, rf_addr, rf_data, busy and rr_ptr. Reset value of rr_ptr is 1.
- Reset asserted mid-operation: the in-flight write in the output register is dropped (rf_wr=0 next cycle) and all claims are discarded.
- Grant, combinational from req_valid and rr_ptr:
  - req_valid[0]=1 -> grant 0 only.
  - Otherwise grant the first valid requester at or after rr_ptr, searching cyclically over 1..NREQ-1.
  - At most one req_ready bit is high. All are 0 when nothing is valid.
  - req_ready never depends on req_data or req_addr.
- Round-robin pointer: when requester k>=1 is granted, rr_ptr <= k+1, wrapping from NREQ to 1. It is unchanged on a grant to 0 or on an idle cycle.
- Starvation of 1..NREQ-1 under continuous req_valid[0] is accepted behaviour. The pipeline by design cannot write every cycle.
- Output register, latency 1 (grant in cycle T appears at the register file in T+1):
  - rf_wr <= (any grant) && (granted addr != 0).
  - rf_addr and rf_data are loaded with the granted request on every grant, including writes to register 0.
  - rf_addr and rf_data hold their values when there is no grant.
  - A write to register 0 is accepted (ready=1) and then dropped.
- Scoreboard update per register r, each cycle:
  - set when claim_valid && claim_addr==r && r!=0;
  - clear when a granted transfer targets r;
  - set and clear on the same r in the same cycle -> set wins (new claim outlives old write).
  - busy[0] is always 0.
  - Claiming an already-busy register keeps it busy (no counting). Issue logic must not double-claim.
  - A write to a non-busy register is legal and leaves busy unchanged.
- busy is registered: it reflects a claim or clear one cycle after the event. It clears in the same cycle that rf_wr commits the write, so a stalled reader can read the value the register file holds after that edge.

Decomposition:
- Shared package rf_pkg: REG_AW=5, REG_DW=32, REG_ZERO=5'd0, REG_SP=5'd29, SP_RESET=32'h7ffffffc, NUM_REGS=32. The package is reused by the register file and the scoreboard.
- One natural sub-module: rr_arb. It is a parameterised round-robin picker: inputs are request vector and pointer; outputs are a one-hot grant and the granted index.
- The top level adds the priority override, the output register and the scoreboard.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then reset=1 -> rf_wr=0, busy=0, req_ready=0.
- Single write: req_valid=3'b010, addr=8, data=32'hDEADBEEF -> req_ready=3'b010 same cycle; next cycle rf_wr=1, rf_addr=8, rf_data=32'hDEADBEEF.
- Priority and round-robin: req_valid=3'b111 held 4 cycles, then 3'b110 for 4 cycles -> grants 0,0,0,0,1,2,1,2.
- Zero register: req0 writes addr=0, data=5 -> req_ready[0]=1, next cycle rf_wr=0.
- Scoreboard: claim 9 in cycle 0 -> busy[9]=1 from cycle 1. In cycle 3, req2 writes 9 and claim 9 is asserted in the same cycle -> busy[9] stays 1. In cycle 5, req2 writes 9 with no claim -> busy[9]=0 from cycle 6.
- Reset mid-operation: claims on regs 4 and 7, req1 granted, reset=0 that cycle -> next cycle rf_wr=0, busy=0, rr_ptr=1.
